// File: rtl/ahb_rom_dual_port_arbiter.sv
// ahb_rom_dual_port_arbiter
//   Shares one single-port synchronous boot ROM between two AHB-lite slave
//   ports. P0 is the core instruction bus, P1 the data/debug bus. Each read
//   beat is arbitrated for the ROM; an uncontested read completes with zero
//   wait states and the losing port of a contested cycle gets one wait state.
//   Writes are answered with a two-cycle ERROR response and never reach the ROM.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   pN_hsel_i .. pN_hready_i  AHB-lite slave inputs for port N (N = 0, 1)
//   pN_hrdata_o               read data (ROM data while in the data phase)
//   pN_hreadyout_o            slave HREADYOUT
//   pN_hresp_o                1 = ERROR
//   rom_req_o, rom_addr_o     ROM read strobe and byte address
//   rom_rdata_i               ROM data, valid the cycle after rom_req_o

// Checks that both ports are never stalled waiting for the ROM at once.
module ahb_rom_dual_port_arbiter_chk (
  input logic clk,
  input logic rstn,
  input logic wait0,
  input logic wait1
);
  a_single_wait: assert property (@(posedge clk) disable iff (!rstn) !(wait0 && wait1));
endmodule

module ahb_rom_dual_port_arbiter #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ROM_ADDR_WIDTH = 16,
  parameter int ROM_OFFSET     = 32'h80,
  parameter bit RR_MODE        = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      p0_hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] p0_haddr_i,
  input  logic                      p0_hwrite_i,
  input  logic [1:0]                p0_htrans_i,
  input  logic                      p0_hready_i,
  output logic [AHB_DATA_WIDTH-1:0] p0_hrdata_o,
  output logic                      p0_hreadyout_o,
  output logic                      p0_hresp_o,
  input  logic                      p1_hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] p1_haddr_i,
  input  logic                      p1_hwrite_i,
  input  logic [1:0]                p1_htrans_i,
  input  logic                      p1_hready_i,
  output logic [AHB_DATA_WIDTH-1:0] p1_hrdata_o,
  output logic                      p1_hreadyout_o,
  output logic                      p1_hresp_o,
  output logic                      rom_req_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [AHB_DATA_WIDTH-1:0] rom_rdata_i
);

  localparam int RAW = ROM_ADDR_WIDTH;
  localparam logic [RAW-1:0] ROM_OFF = RAW'(ROM_OFFSET);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  logic [1:0]     hsel_s, hready_s, hwrite_s, htrans_nsq_s;
  logic [RAW-1:0] haddr_s [2];

  state_e         state_q [2];
  state_e         state_d [2];
  logic [RAW-1:0] pend_addr_q [2];
  logic [RAW-1:0] pend_addr_d [2];
  logic [1:0]     hreadyout_q, hreadyout_d;
  logic [1:0]     hresp_q, hresp_d;
  logic           rr_last_q, rr_last_d;   // 1 = P1 was granted last

  logic [1:0]     accept_s, rd_s, wr_s, waiting_s, grant_s;
  logic           contested_s;
  logic [RAW-1:0] sel_addr_s;
  logic           unused_s;

  assign hsel_s       = {p1_hsel_i, p0_hsel_i};
  assign hready_s     = {p1_hready_i, p0_hready_i};
  assign hwrite_s     = {p1_hwrite_i, p0_hwrite_i};
  assign htrans_nsq_s = {p1_htrans_i[1], p0_htrans_i[1]};
  assign haddr_s[0]   = p0_haddr_i[RAW-1:0];
  assign haddr_s[1]   = p1_haddr_i[RAW-1:0];

  // Upper address bits and htrans[0] play no part in a ROM read.
  assign unused_s = ^{p0_haddr_i[AHB_ADDR_WIDTH-1:RAW], p1_haddr_i[AHB_ADDR_WIDTH-1:RAW],
                      p0_htrans_i[0], p1_htrans_i[0]};

  // Transfer qualification and one-per-cycle ROM grant.
  always_comb begin
    accept_s    = 2'b00;
    rd_s        = 2'b00;
    wr_s        = 2'b00;
    waiting_s   = 2'b00;
    for (int n = 0; n < 2; n++) begin
      waiting_s[n] = (state_q[n] == ST_WAIT);
      // Only states that present HREADYOUT=1 with no pending beat take a new address.
      if (state_q[n] == ST_IDLE || state_q[n] == ST_DATA || state_q[n] == ST_ERR2) begin
        accept_s[n] = rstn & hsel_s[n] & hready_s[n] & htrans_nsq_s[n];
      end else begin
        accept_s[n] = 1'b0;
      end
      rd_s[n] = accept_s[n] & ~hwrite_s[n];
      wr_s[n] = accept_s[n] & hwrite_s[n];
    end
    contested_s = rd_s[0] & rd_s[1] & ~waiting_s[0] & ~waiting_s[1];

    // A port already stalled owns the ROM; otherwise at most one fresh read
    // survives the contest.
    grant_s = 2'b00;
    if (!rstn) begin
      grant_s = 2'b00;
    end else if (waiting_s[0]) begin
      grant_s = 2'b01;
    end else if (waiting_s[1]) begin
      grant_s = 2'b10;
    end else if (contested_s) begin
      if (RR_MODE && !rr_last_q) begin
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b01;
      end
    end else begin
      grant_s = rd_s;
    end

    if (contested_s) begin
      rr_last_d = grant_s[1];
    end else begin
      rr_last_d = rr_last_q;
    end

    sel_addr_s = '0;
    if (grant_s[1]) begin
      sel_addr_s = waiting_s[1] ? pend_addr_q[1] : haddr_s[1];
    end else if (grant_s[0]) begin
      sel_addr_s = waiting_s[0] ? pend_addr_q[0] : haddr_s[0];
    end else begin
      sel_addr_s = '0;
    end
  end

  assign rom_req_o  = |grant_s;
  // Wraps modulo 2^RAW, so addresses below the offset alias to the top of the ROM.
  assign rom_addr_o = rom_req_o ? (sel_addr_s - ROM_OFF) : '0;

  // Per-port next state, pending address and next registered response.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      state_d[n]     = state_q[n];
      pend_addr_d[n] = pend_addr_q[n];
      case (state_q[n])
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (wr_s[n]) begin
            state_d[n] = ST_ERR1;
          end else if (rd_s[n] && grant_s[n]) begin
            state_d[n] = ST_DATA;
          end else if (rd_s[n]) begin
            state_d[n]     = ST_WAIT;
            pend_addr_d[n] = haddr_s[n];
          end else begin
            state_d[n] = ST_IDLE;
          end
        end
        ST_WAIT: state_d[n] = ST_DATA;
        ST_ERR1: state_d[n] = ST_ERR2;
        default: state_d[n] = ST_IDLE;
      endcase

      case (state_d[n])
        ST_WAIT: begin
          hreadyout_d[n] = 1'b0;
          hresp_d[n]     = 1'b0;
        end
        ST_ERR1: begin
          hreadyout_d[n] = 1'b0;
          hresp_d[n]     = 1'b1;
        end
        ST_ERR2: begin
          hreadyout_d[n] = 1'b1;
          hresp_d[n]     = 1'b1;
        end
        default: begin
          hreadyout_d[n] = 1'b1;
          hresp_d[n]     = 1'b0;
        end
      endcase
    end
  end

  // State, pending address, response and round-robin registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n]     <= ST_IDLE;
        pend_addr_q[n] <= '0;
      end
      hreadyout_q <= 2'b11;
      hresp_q     <= 2'b00;
      rr_last_q   <= 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        state_q[n]     <= state_d[n];
        pend_addr_q[n] <= pend_addr_d[n];
      end
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      rr_last_q   <= rr_last_d;
    end
  end

  // ROM data is only valid in the cycle after the grant, so it is steered
  // straight through to the port sitting in its data phase.
  assign p0_hrdata_o    = (state_q[0] == ST_DATA) ? rom_rdata_i : '0;
  assign p1_hrdata_o    = (state_q[1] == ST_DATA) ? rom_rdata_i : '0;
  assign p0_hreadyout_o = hreadyout_q[0];
  assign p1_hreadyout_o = hreadyout_q[1];
  assign p0_hresp_o     = hresp_q[0];
  assign p1_hresp_o     = hresp_q[1];

  ahb_rom_dual_port_arbiter_chk u_chk (
    .clk   (clk),
    .rstn  (rstn),
    .wait0 (waiting_s[0]),
    .wait1 (waiting_s[1])
  );

endmodule

// File: tb/tb_ahb_rom_dual_port_arbiter.sv
// Bench for ahb_rom_dual_port_arbiter: one fixed-priority and one round-robin
// instance share the same master stimulus; a transaction-level reference
// schedules the response each port owes in the coming cycles.
module tb_ahb_rom_dual_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel [2];
  logic        wr [2];
  logic [1:0]  tr [2];
  logic [31:0] addr [2];
  logic        hrdy_in [2][2];
  logic [31:0] hrdata [2][2];
  logic        hro [2][2];
  logic        hresp [2][2];
  logic        rom_req [2];
  logic [15:0] rom_addr [2];
  logic [31:0] rom_q [2];

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic        chk;
    logic [31:0] data;
  } rsp_t;

  localparam rsp_t OKAY_RSP = '{rdy: 1'b1, resp: 1'b0, chk: 1'b1, data: 32'h0};

  rsp_t        cur [2][2];   // response each port owes this cycle
  rsp_t        nx1 [2][2];   // response owed in the following cycle
  logic        owed [2][2];  // read lost arbitration, ROM owed next cycle
  logic [15:0] owed_a [2][2];
  int          rr_last [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Behavioural ROM: one-cycle read latency.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rom_req[d]) rom_q[d] <= rom_word(rom_addr[d]);
    end
  end

  ahb_rom_dual_port_arbiter #(.RR_MODE(1'b0)) u_fix (
    .clk(clk), .rstn(rstn),
    .p0_hsel_i(sel[0]), .p0_haddr_i(addr[0]), .p0_hwrite_i(wr[0]), .p0_htrans_i(tr[0]),
    .p0_hready_i(hrdy_in[0][0]), .p0_hrdata_o(hrdata[0][0]), .p0_hreadyout_o(hro[0][0]),
    .p0_hresp_o(hresp[0][0]),
    .p1_hsel_i(sel[1]), .p1_haddr_i(addr[1]), .p1_hwrite_i(wr[1]), .p1_htrans_i(tr[1]),
    .p1_hready_i(hrdy_in[0][1]), .p1_hrdata_o(hrdata[0][1]), .p1_hreadyout_o(hro[0][1]),
    .p1_hresp_o(hresp[0][1]),
    .rom_req_o(rom_req[0]), .rom_addr_o(rom_addr[0]), .rom_rdata_i(rom_q[0])
  );

  ahb_rom_dual_port_arbiter #(.RR_MODE(1'b1)) u_rr (
    .clk(clk), .rstn(rstn),
    .p0_hsel_i(sel[0]), .p0_haddr_i(addr[0]), .p0_hwrite_i(wr[0]), .p0_htrans_i(tr[0]),
    .p0_hready_i(hrdy_in[1][0]), .p0_hrdata_o(hrdata[1][0]), .p0_hreadyout_o(hro[1][0]),
    .p0_hresp_o(hresp[1][0]),
    .p1_hsel_i(sel[1]), .p1_haddr_i(addr[1]), .p1_hwrite_i(wr[1]), .p1_htrans_i(tr[1]),
    .p1_hready_i(hrdy_in[1][1]), .p1_hrdata_o(hrdata[1][1]), .p1_hreadyout_o(hro[1][1]),
    .p1_hresp_o(hresp[1][1]),
    .rom_req_o(rom_req[1]), .rom_addr_o(rom_addr[1]), .rom_rdata_i(rom_q[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        cur[d][n]    = OKAY_RSP;
        nx1[d][n]    = OKAY_RSP;
        owed[d][n]   = 1'b0;
        owed_a[d][n] = 16'h0;
      end
      rr_last[d] = 1;
    end
  endtask

  // One bus cycle: drive, check at the falling edge, advance the reference.
  task automatic cycle(input bit rst, input bit s0, input bit w0, input logic [1:0] t0,
                       input logic [31:0] a0, input bit s1, input bit w1,
                       input logic [1:0] t1, input logic [31:0] a1,
                       input bit hlow0, input bit hlow1);
    rstn = ~rst;
    sel[0] = s0; wr[0] = w0; tr[0] = t0; addr[0] = a0;
    sel[1] = s1; wr[1] = w1; tr[1] = t1; addr[1] = a1;
    for (int d = 0; d < 2; d++) begin
      hrdy_in[d][0] = cur[d][0].rdy & ~hlow0;
      hrdy_in[d][1] = cur[d][1].rdy & ~hlow1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [1:0]  rd;
      logic [1:0]  wa;
      int          g;
      logic [15:0] ga;
      for (int n = 0; n < 2; n++) begin
        logic acc;
        acc   = ~rst & sel[n] & hrdy_in[d][n] & tr[n][1];
        rd[n] = acc & ~wr[n];
        wa[n] = acc & wr[n];
      end
      g = -1;
      if (rst) g = -1;
      else if (owed[d][0]) g = 0;
      else if (owed[d][1]) g = 1;
      else if (rd[0] && rd[1]) begin
        g = (d == 1 && rr_last[d] == 0) ? 1 : 0;
        rr_last[d] = g;
      end
      else if (rd[0]) g = 0;
      else if (rd[1]) g = 1;
      ga = 16'h0;
      if (g >= 0) ga = (owed[d][g] ? owed_a[d][g] : addr[g][15:0]) - 16'h0080;

      check_val($sformatf("d%0d_rom_req", d), {31'h0, rom_req[d]}, {31'h0, g >= 0});
      if (g >= 0) check_val($sformatf("d%0d_rom_addr", d), {16'h0, rom_addr[d]}, {16'h0, ga});
      for (int n = 0; n < 2; n++) begin
        check_val($sformatf("d%0d_p%0d_hreadyout", d, n), {31'h0, hro[d][n]}, {31'h0, cur[d][n].rdy});
        check_val($sformatf("d%0d_p%0d_hresp", d, n), {31'h0, hresp[d][n]}, {31'h0, cur[d][n].resp});
        if (cur[d][n].chk)
          check_val($sformatf("d%0d_p%0d_hrdata", d, n), hrdata[d][n], cur[d][n].data);
      end

      if (rst) begin
        for (int n = 0; n < 2; n++) begin
          cur[d][n] = OKAY_RSP; nx1[d][n] = OKAY_RSP; owed[d][n] = 1'b0;
        end
        rr_last[d] = 1;
      end else begin
        for (int n = 0; n < 2; n++) begin
          cur[d][n] = nx1[d][n];
          nx1[d][n] = OKAY_RSP;
          if (g == n) begin
            cur[d][n]  = '{rdy: 1'b1, resp: 1'b0, chk: 1'b1, data: rom_word(ga)};
            owed[d][n] = 1'b0;
          end else if (rd[n]) begin
            cur[d][n]    = '{rdy: 1'b0, resp: 1'b0, chk: 1'b0, data: 32'h0};
            owed[d][n]   = 1'b1;
            owed_a[d][n] = addr[n][15:0];
          end else if (wa[n]) begin
            cur[d][n] = '{rdy: 1'b0, resp: 1'b1, chk: 1'b0, data: 32'h0};
            nx1[d][n] = '{rdy: 1'b1, resp: 1'b1, chk: 1'b0, data: 32'h0};
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom();
    r[15:0] = 16'($urandom_range(0, 511)) << 2;
    return r;
  endfunction

  initial begin
    for (int n = 0; n < 2; n++) begin
      sel[n] = 1'b0; wr[n] = 1'b0; tr[n] = 2'd0; addr[n] = 32'h0;
      hrdy_in[0][n] = 1'b1; hrdy_in[1][n] = 1'b1;
    end
    model_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(1);
    // Single uncontested read at the ROM base.
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h80, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    idle(1);
    // Contested pair: P0 then P1 from its latched address.
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h84, 1'b1, 1'b0, 2'd2, 32'h90, 1'b0, 1'b0);
    idle(2);
    // Write to P1 gets the two-cycle error.
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h100, 1'b0, 1'b0);
    idle(3);
    // P0 four-beat burst with a P1 read arriving on beat 2.
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'hA0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd3, 32'hA4, 1'b1, 1'b0, 2'd2, 32'hC0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd3, 32'hA8, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'd3, 32'hAC, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    idle(2);
    // Three contested pairs, each allowed to drain.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h200 + 32'(k * 8), 1'b1, 1'b0, 2'd2, 32'h300 + 32'(k * 8), 1'b0, 1'b0);
      idle(2);
    end
    // Reset while P1 is stalled: the pending beat is dropped.
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h88, 1'b1, 1'b0, 2'd2, 32'h8C, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    idle(2);
    // Address below the offset wraps.
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h4, 1'b0, 1'b0);
    idle(1);
    // Randomised traffic, occasional bus-level HREADY low and resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), rand_addr(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), rand_addr(),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_rom_dual_port_arbiter.md
Name: ahb_rom_dual_port_arbiter

Overview:
- Shares one single-port synchronous boot ROM between two AHB-lite slave ports.
- P0 is the core instruction bus; P1 is the core data bus or the debug bus.
- Arbitrates per-beat ROM reads with zero wait states when uncontested and one wait state for the losing port.
- Rejects writes with a two-cycle AHB ERROR response. Sits between the bus matrix and boot_rom.

Parameters:
- AHB_ADDR_WIDTH, 32, AHB address width.
- AHB_DATA_WIDTH, 32, AHB data width; equals ROM word width.
- ROM_ADDR_WIDTH, 16, number of low haddr bits forwarded to the ROM.
- ROM_OFFSET, 'h80, constant subtracted from haddr[ROM_ADDR_WIDTH-1:0] to form rom_addr_o; the subtraction wraps modulo 2^ROM_ADDR_WIDTH.
- RR_MODE, 0, 0 = fixed priority (P0 wins), 1 = round-robin between fresh requests.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- pN_hsel_i  in  1  slave select, for N = 0 and N = 1
- pN_haddr_i  in  AHB_ADDR_WIDTH  address
- pN_hwrite_i  in  1  write = 1
- pN_htrans_i  in  2  AHB transfer type
- pN_hready_i  in  1  bus-level HREADY
- pN_hrdata_o  out  AHB_DATA_WIDTH  read data
- pN_hreadyout_o  out  1  slave HREADYOUT
- pN_hresp_o  out  1  1 = ERROR
- rom_req_o  out  1  ROM read strobe
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM byte address
- rom_rdata_i  in  AHB_DATA_WIDTH  ROM data, valid the cycle after rom_req_o

Behaviour:
- Accept on port N: pN_hsel_i & pN_hready_i & pN_htrans_i[1]. IDLE and BUSY transfers are ignored and get an OKAY response.
- Per-port FSM, states IDLE, WAIT, DATA, ERR1, ERR2. Reset state is IDLE.
- From IDLE or DATA:
  - accepted write -> ERR1.
  - accepted read that is granted this cycle -> DATA.
  - accepted read that is not granted -> WAIT; latch haddr into pend_addrN.
  - otherwise -> IDLE.
- WAIT: port N is always granted this cycle -> DATA. A WAIT port wins over any fresh request.
- ERR1 -> ERR2 unconditionally. ERR2 then behaves like IDLE for a new accept.
- Grant, one per cycle:
  - The WAIT port, if any, takes the grant.
  - Otherwise, with fresh reads on both ports: RR_MODE=0 gives P0; RR_MODE=1 gives the port not granted most recently.
  - The rr pointer updates only on contested fresh grants and resets to "P1 last", so P0 wins first.
  - Both ports cannot be in WAIT at once; the RTL asserts this.
- ROM drive, combinational:
  - rom_req_o = 1 in any cycle with a grant.
  - rom_addr_o = (granted port in WAIT ? pend_addrN : pN_haddr_i)[ROM_ADDR_WIDTH-1:0] - ROM_OFFSET.
  - No ROM request is issued for writes.
- Outputs per state:
  - IDLE/ERR2 (OKAY case): hreadyout=1, hresp=0, hrdata=0.
  - WAIT: hreadyout=0, hresp=0.
  - DATA: hreadyout=1, hresp=0, hrdata=rom_rdata_i.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Latency: an uncontested read delivers data in the cycle after the address phase, with 0 wait states. The loser gets 1 wait state, and data arrives 2 cycles after its address phase.
- Back-to-back: a port in DATA may accept its next address phase in the same cycle. The pipelined request follows the normal grant rules.
- hready_i low: no new accept. A port already in WAIT still completes, because its address is latched.
- Reset: every port returns to IDLE the next edge. Pending requests are dropped, rom_req_o=0, hreadyout=1, hresp=0, hrdata=0.

Test Plan:
- P0 reads 0x80 with P1 idle -> rom_req_o=1 and rom_addr_o=0x0000 in the same cycle; next cycle p0_hreadyout_o=1 and p0_hrdata_o=ROM[0].
- P0 reads 0x84 and P1 reads 0x90 in the same cycle, RR_MODE=0 -> P0 gets data at +1 cycle. P1 has hreadyout=0 at +1, during which rom_addr_o=0x10 comes from the latched address; P1 gets data at +2.
- RR_MODE=1, three consecutive contested pairs -> grant order P0, P1, P0. The WAIT port is serviced before the next fresh contention.
- P1 write to 0x100 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); rom_req_o stays 0 throughout.
- P0 issues a 4-beat SEQ burst while P1 issues a single read mid-burst -> the fixed-priority stall sequence matches the model, and all data matches ROM contents.
- rstn low while P1 is in WAIT -> the next cycle P1 is IDLE, p1_hreadyout_o=1, and no rom_req_o is issued for the dropped request.
